// File: rtl/pad_bank_pkg.sv
// Shared types and default constants for the pad bank controller.
package pad_bank_pkg;

    // Controller phases: idle, driving the pads, bus turnaround, reading.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_TA   = 2'd2,
        ST_RX   = 2'd3
    } bank_state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_TURN_CYC = 2;
    localparam int DEF_SYNC_STG = 2;

    // Wide enough for the largest turnaround (15) and sync depth (4).
    localparam int CNT_W = 4;

endpackage

// File: rtl/pad_bank_ctrl_pad_sync.sv
// Multi-flop synchroniser for the pad inputs; runs every cycle regardless
// of what the controller is doing.
module pad_sync
    import pad_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SYNC_STG = DEF_SYNC_STG
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [SYNC_STG];

    generate
        for (genvar gi = 0; gi < SYNC_STG; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage samples the raw pad value.
                always_ff @(posedge CK) begin
                    if (RST) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= din;
                end
            end else begin : g_rest
                // Later stages shift the sample along the chain.
                always_ff @(posedge CK) begin
                    if (RST) stage_reg[gi] <= '0;
                    else     stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[SYNC_STG-1];

endmodule

// File: rtl/pad_bank_ctrl.sv
// Bidirectional pad bank controller: write bursts onto the pads, a fixed
// turnaround after each burst, and synchronised single-word reads.
module pad_bank_ctrl
    import pad_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TURN_CYC = DEF_TURN_CYC,
    parameter int SYNC_STG = DEF_SYNC_STG
) (
    input  logic             CK,
    input  logic             RST,
    inout  wire  [WIDTH-1:0] PAD,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             OEN,
    output logic             busy
);

    // Counter reload values: the phase lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LOAD = CNT_W'(SYNC_STG - 1);

    bank_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             oen_reg;
    logic [WIDTH-1:0] sync_out;

    pad_sync #(
        .WIDTH    (WIDTH),
        .SYNC_STG (SYNC_STG)
    ) u_pad_sync (
        .CK   (CK),
        .RST  (RST),
        .din  (PAD),
        .dout (sync_out)
    );

    // Next-state, counter and capture decisions.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        out_next      = out_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A write beats a read issued on the same edge; the read is lost.
                if (tx_valid) begin
                    state_next = ST_TX;
                    out_next   = tx_data;
                end else if (rx_req) begin
                    state_next = ST_RX;
                    cnt_next   = RX_LOAD;
                end
            end
            ST_TX: begin
                if (tx_valid) begin
                    out_next = tx_data;
                end else begin
                    state_next = ST_TA;
                    cnt_next   = TA_LOAD;
                end
            end
            ST_TA: begin
                if (cnt_reg == '0) state_next = ST_IDLE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            ST_RX: begin
                // By the last RX cycle the synchroniser holds a settled pad sample.
                if (cnt_reg == '0) begin
                    state_next    = ST_IDLE;
                    rx_data_next  = sync_out;
                    rx_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; OEN follows the state being entered.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            out_reg      <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            oen_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            out_reg      <= out_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            oen_reg      <= (state_next != ST_TX);
        end
    end

    assign PAD      = oen_reg ? {WIDTH{1'bz}} : out_reg;
    assign OEN      = oen_reg;
    assign tx_ready = (state_reg == ST_IDLE) || (state_reg == ST_TX);
    assign busy     = (state_reg != ST_IDLE);
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Self-checking bench for pad_bank_ctrl (WIDTH=4, TURN_CYC=2, SYNC_STG=2).
module tb_pad_bank_ctrl;

    localparam int W   = 4;
    localparam int TA  = 2;
    localparam int SYN = 2;

    logic         CK = 1'b0;
    logic         RST;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         rx_req;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         OEN;
    logic         busy;
    wire  [W-1:0] PAD;

    // Bench plays the external device: it drives the pads whenever the DUT lets go.
    logic [W-1:0] tb_val;
    assign PAD = OEN ? tb_val : {W{1'bz}};

    int total = 0;
    int bad   = 0;

    pad_bank_ctrl #(.WIDTH(W), .TURN_CYC(TA), .SYNC_STG(SYN)) dut (
        .CK(CK), .RST(RST), .PAD(PAD), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_req(rx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .OEN(OEN), .busy(busy)
    );

    always #5 CK = ~CK;

    // Behavioural model: "driving" flag plus remaining-cycle counts for the
    // turnaround and read windows, and a queue of pad samples in flight.
    bit           m_drive;
    int           m_ta_left;
    int           m_rx_left;
    logic [W-1:0] m_out;
    logic [W-1:0] m_rxd;
    bit           m_rxv;
    logic [W-1:0] m_sync [$];
    logic [W-1:0] pad_snap;

    task automatic model_edge(input bit tv, input logic [W-1:0] td, input bit rr, input bit rs);
        logic [W-1:0] oldest;
        if (rs) begin
            m_drive = 0; m_ta_left = 0; m_rx_left = 0;
            m_out = '0; m_rxd = '0; m_rxv = 0;
            m_sync.delete();
            for (int i = 0; i < SYN; i++) m_sync.push_back('0);
        end else begin
            oldest = m_sync.pop_front();
            m_sync.push_back(pad_snap);
            m_rxv = 0;
            if (m_drive) begin
                if (tv) m_out = td;
                else begin m_drive = 0; m_ta_left = TA; end
            end else if (m_ta_left > 0) begin
                m_ta_left--;
            end else if (m_rx_left > 0) begin
                m_rx_left--;
                if (m_rx_left == 0) begin m_rxd = oldest; m_rxv = 1; end
            end else if (tv) begin
                m_drive = 1; m_out = td;
            end else if (rr) begin
                m_rx_left = SYN;
            end
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit tv, input logic [W-1:0] td, input bit rr, input bit rs);
        tx_valid = tv; tx_data = td; rx_req = rr; RST = rs;
        #1;
        pad_snap = PAD;
        @(posedge CK);
        model_edge(tv, td, rr, rs);
        @(negedge CK);
    endtask

    task automatic test_reset();
        tb_val = 4'h0;
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);
        total++; if (OEN !== 1'b1)      begin bad++; $display("FAIL reset_oen got=%b want=1", OEN); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rx_data !== 4'h0)  begin bad++; $display("FAIL reset_rx_data got=%h want=0", rx_data); end
        step(0, 4'h0, 0, 0);
        $display("txn reset: OEN=%b tx_ready=%b busy=%b", OEN, tx_ready, busy);
    endtask

    task automatic test_single_write();
        step(1, 4'hA, 0, 0);
        total++; if (OEN !== 1'b0) begin bad++; $display("FAIL single_oen got=%b want=0", OEN); end
        total++; if (PAD !== 4'hA) begin bad++; $display("FAIL single_pad got=%h want=a", PAD); end
        for (int i = 0; i < TA; i++) begin
            step(0, 4'h0, 0, 0);
            total++; if (OEN !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b1)
                begin bad++; $display("FAIL single_ta%0d got oen=%b rdy=%b busy=%b want 1 0 1", i, OEN, tx_ready, busy); end
        end
        step(0, 4'h0, 0, 0);
        total++; if (tx_ready !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL single_idle got rdy=%b busy=%b want 1 0", tx_ready, busy); end
        $display("txn single_write: word=a");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h9;
        for (int i = 0; i < 3; i++) begin
            step(1, words[i], 0, 0);
            total++; if (OEN !== 1'b0 || PAD !== words[i])
                begin bad++; $display("FAIL b2b_word%0d got oen=%b pad=%h want 0 %h", i, OEN, PAD, words[i]); end
        end
        for (int i = 0; i < TA; i++) begin
            step(0, 4'h0, 0, 0);
            total++; if (OEN !== 1'b1 || tx_ready !== 1'b0)
                begin bad++; $display("FAIL b2b_ta%0d got oen=%b rdy=%b want 1 0", i, OEN, tx_ready); end
        end
        step(0, 4'h0, 0, 0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        $display("txn back_to_back: words=3,5,9");
    endtask

    task automatic test_read();
        tb_val = 4'h6;
        step(0, 4'h0, 0, 0);
        step(0, 4'h0, 0, 0);
        step(0, 4'h0, 1, 0);
        total++; if (rx_valid !== 1'b0 || OEN !== 1'b1 || tx_ready !== 1'b0)
            begin bad++; $display("FAIL read_wait0 got v=%b oen=%b rdy=%b want 0 1 0", rx_valid, OEN, tx_ready); end
        step(0, 4'h0, 0, 0);
        total++; if (rx_valid !== 1'b0 || OEN !== 1'b1)
            begin bad++; $display("FAIL read_wait1 got v=%b oen=%b want 0 1", rx_valid, OEN); end
        step(0, 4'h0, 0, 0);
        total++; if (rx_valid !== 1'b1 || rx_data !== 4'h6)
            begin bad++; $display("FAIL read_capture got v=%b d=%h want 1 6", rx_valid, rx_data); end
        tb_val = 4'h1;
        step(0, 4'h0, 0, 0);
        total++; if (rx_valid !== 1'b0 || rx_data !== 4'h6 || busy !== 1'b0)
            begin bad++; $display("FAIL read_hold got v=%b d=%h busy=%b want 0 6 0", rx_valid, rx_data, busy); end
        $display("txn read: data=%h", rx_data);
    endtask

    task automatic test_collision();
        bit seen;
        seen = 0;
        tb_val = 4'h2;
        step(1, 4'hC, 1, 0);
        total++; if (OEN !== 1'b0 || PAD !== 4'hC)
            begin bad++; $display("FAIL collide_pad got oen=%b pad=%h want 0 c", OEN, PAD); end
        for (int i = 0; i < 8; i++) begin
            step(0, 4'h0, 0, 0);
            if (rx_valid === 1'b1) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL collide_rx got rx_valid=1 want never"); end
        $display("txn collision: word=c read dropped");
    endtask

    task automatic test_reset_mid();
        step(1, 4'h7, 0, 0);
        step(1, 4'h8, 0, 0);
        step(1, 4'h9, 0, 1);
        total++; if (OEN !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL rst_tx got oen=%b rdy=%b busy=%b want 1 1 0", OEN, tx_ready, busy); end
        step(0, 4'h0, 0, 0);
        total++; if (busy !== 1'b0 || tx_ready !== 1'b1)
            begin bad++; $display("FAIL rst_tx_noTA got busy=%b rdy=%b want 0 1", busy, tx_ready); end
        step(0, 4'h0, 1, 0);
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'h0, 0, 0);
            total++; if (rx_valid !== 1'b0)
                begin bad++; $display("FAIL rst_rx%0d got rx_valid=%b want 0", i, rx_valid); end
        end
        $display("txn reset_mid: tx and rx aborted");
    endtask

    task automatic test_random();
        bit tv, rr, rs;
        logic [W-1:0] td;
        step(0, 4'h0, 0, 1);
        for (int n = 0; n < 400; n++) begin
            tv = ($urandom_range(0, 99) < 45);
            rr = ($urandom_range(0, 99) < 40);
            rs = ($urandom_range(0, 99) < 3);
            td = W'($urandom);
            tb_val = W'($urandom);
            step(tv, td, rr, rs);
            total++; if (OEN !== !m_drive)
                begin bad++; $display("FAIL rnd%0d_oen got=%b want=%b", n, OEN, !m_drive); end
            total++; if (tx_ready !== (m_ta_left == 0 && m_rx_left == 0))
                begin bad++; $display("FAIL rnd%0d_tx_ready got=%b want=%b", n, tx_ready, (m_ta_left == 0 && m_rx_left == 0)); end
            total++; if (busy !== (m_drive || m_ta_left > 0 || m_rx_left > 0))
                begin bad++; $display("FAIL rnd%0d_busy got=%b want=%b", n, busy, (m_drive || m_ta_left > 0 || m_rx_left > 0)); end
            total++; if (rx_valid !== m_rxv || rx_data !== m_rxd)
                begin bad++; $display("FAIL rnd%0d_rx got v=%b d=%h want v=%b d=%h", n, rx_valid, rx_data, m_rxv, m_rxd); end
            if (m_drive) begin
                total++; if (PAD !== m_out)
                    begin bad++; $display("FAIL rnd%0d_pad got=%h want=%h", n, PAD, m_out); end
            end
            $display("txn rnd%0d: tv=%b td=%h rr=%b rst=%b -> oen=%b rdy=%b busy=%b rxv=%b rxd=%h",
                     n, tv, td, rr, rs, OEN, tx_ready, busy, rx_valid, rx_data);
        end
    endtask

    initial begin
        RST = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0; tb_val = '0;
        m_drive = 0; m_ta_left = 0; m_rx_left = 0; m_out = '0; m_rxd = '0; m_rxv = 0;
        for (int i = 0; i < SYN; i++) m_sync.push_back('0);
        @(negedge CK);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_bank_ctrl.md
PAD_BANK_CTRL -- requirements
Module: pad_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of bidirectional pad bits in the bank.
REQ-002 Parameter TURN_CYC, default 2: bus-turnaround cycles after a drive burst; legal range 1..15.
REQ-003 Parameter SYNC_STG, default 2: input synchroniser depth; legal range 2..4.
REQ-004 CK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 PAD  inout  WIDTH  bidirectional pad bus.
REQ-007 tx_data  input  WIDTH  word to drive onto PAD.
REQ-008 tx_valid  input  1  tx_data valid.
REQ-009 tx_ready  output  1  write accepted on an edge where tx_valid and tx_ready are both high.
REQ-010 rx_req  input  1  read request, sampled only in IDLE.
REQ-011 rx_data  output  WIDTH  captured pad value.
REQ-012 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-013 OEN  output  1  active-low pad output enable (registered).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, TX, TA (turnaround), RX; all outputs SHALL be registered or decoded from registered state only.
REQ-016 PAD SHALL equal out_reg when OEN=0 and all-Z when OEN=1; OEN SHALL be 0 only in TX.
REQ-017 tx_ready SHALL be 1 in IDLE and TX, 0 in TA and RX.
REQ-018 IDLE: accepted tx_valid -> TX with out_reg<=tx_data; else rx_req -> RX; else stay.
REQ-019 Simultaneous tx_valid and rx_req in IDLE: write SHALL win; rx_req SHALL be dropped (not queued).
REQ-020 TX: each edge with tx_valid=1 SHALL load the next word and stay in TX (one word per cycle, no bubbles); tx_valid=0 -> TA.
REQ-021 TA: PAD released; counter loaded with TURN_CYC-1 on entry; state SHALL be TA for exactly TURN_CYC cycles, then IDLE; tx_valid and rx_req ignored.
REQ-022 PAD SHALL feed a SYNC_STG-flop synchroniser clocked continuously, independent of state.
REQ-023 RX: state SHALL be RX for exactly SYNC_STG cycles, then IDLE; on the RX-exit edge rx_data<=synchroniser output and rx_valid<=1 for one cycle.
REQ-024 Read latency: rx_req sampled at edge n SHALL give rx_valid high in the cycle after edge n+SYNC_STG.
REQ-025 rx_data SHALL hold its last value until the next capture.
REQ-026 TX is never entered directly from RX; RX exits through IDLE only.

Reset
REQ-027 RST high at an edge SHALL force state=IDLE, OEN=1, out_reg=0, rx_data=0, rx_valid=0, counters=0, synchroniser flops=0.
REQ-028 RST mid-TX SHALL release PAD at that same edge (no turnaround); RST mid-RX SHALL suppress the pending rx_valid.
REQ-029 After reset: tx_ready=1, busy=0.

Structure
REQ-030 Package pad_bank_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Sub-module pad_sync (parameters WIDTH, SYNC_STG) SHALL implement the synchroniser; all else flat in pad_bank_ctrl.

Verification (WIDTH=4, TURN_CYC=2, SYNC_STG=2)
REQ-032 RST high 2 cycles, no other stimulus -> OEN=1, PAD=4'bzzzz, rx_valid=0, tx_ready=1, busy=0.
REQ-033 tx_data=4'hA with tx_valid for 1 cycle -> PAD=4'hA for 1 cycle, then OEN=1 and tx_ready=0 for 2 cycles, then IDLE.
REQ-034 tx words 4'h3, 4'h5, 4'h9 on consecutive cycles -> PAD shows 3,5,9 on consecutive cycles, OEN=0 for 3 cycles, then 2-cycle TA.
REQ-035 Bench drives PAD=4'h6; rx_req pulsed in IDLE at edge n -> rx_valid high 1 cycle after edge n+2 with rx_data=4'h6; PAD never driven by DUT.
REQ-036 tx_valid (4'hC) and rx_req together in IDLE -> PAD=4'hC, no rx_valid ever results.
REQ-037 RST asserted during TX burst -> OEN=1 and PAD=Z from that edge; tx_ready=1 next cycle, no TA cycles.
